// File: rtl/reg_dump_if.sv
// reg_dump_if: bus bundle for the register dump engine.
//   Read-port side : ra, req (engine -> arbiter/regfile), rd, gnt (back).
//   Stream side    : out_valid, out_data, out_idx, out_last (engine -> consumer),
//                    out_ready (consumer -> engine).
// Handshake rules, for every user of this bundle:
//   - A beat transfers on a rising edge where out_valid && out_ready.
//   - While out_valid is high, out_data/out_idx/out_last are stable and
//     out_valid does not drop until the beat transfers or the dump is aborted.
//   - rd is sampled only on an edge where req && gnt; ra is stable while req
//     is high and gnt is low.
// master = dump engine, slave = environment (regfile port, arbiter, consumer).
interface reg_dump_if #(
  parameter int DW = 32,
  parameter int AW = 5
);
  logic [AW-1:0] ra;
  logic [DW-1:0] rd;
  logic          req;
  logic          gnt;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [AW-1:0] out_idx;
  logic          out_last;

  modport master (
    output ra, req, out_valid, out_data, out_idx, out_last,
    input  rd, gnt, out_ready
  );

  modport slave (
    input  ra, req, out_valid, out_data, out_idx, out_last,
    output rd, gnt, out_ready
  );
endinterface

// File: rtl/reg_dump.sv
// reg_dump: read-side debug engine for the register file.
// On an accepted start pulse it walks the inclusive index range first..last
// (wrapping mod NREGS) through a borrowed read port and streams each word out,
// tagged with its index, on a valid/ready channel.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start_i           one-cycle start pulse (ignored while busy)
//   abort_i           synchronous abort of a dump in progress
//   first_i, last_i   inclusive index range, sampled on accepted start
//   bus               reg_dump_if.master (read port + output stream)
//   busy_o            dump in progress
//   done_o            one-cycle pulse after the final beat is accepted
//   state_o           current FSM state (IDLE=0, FETCH=1, SEND=2)
module reg_dump #(
  parameter int DW    = 32,
  parameter int AW    = 5,
  parameter int NREGS = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start_i,
  input  logic          abort_i,
  input  logic [AW-1:0] first_i,
  input  logic [AW-1:0] last_i,
  reg_dump_if.master    bus,
  output logic          busy_o,
  output logic          done_o,
  output logic [1:0]    state_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SEND  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] idx_q,   idx_d;
  logic [AW-1:0] end_q,   end_d;
  logic [AW-1:0] oidx_q,  oidx_d;
  logic [DW-1:0] data_q,  data_d;
  logic          last_q,  last_d;
  logic          done_q,  done_d;
  logic [AW-1:0] idx_next;

  // Index advance wraps from NREGS-1 back to 0.
  assign idx_next = (idx_q == AW'(NREGS - 1)) ? '0 : idx_q + 1'b1;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    end_d   = end_q;
    oidx_d  = oidx_q;
    data_d  = data_q;
    last_d  = last_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        // abort is meaningless here, so a simultaneous start always wins.
        if (start_i) begin
          idx_d   = first_i;
          end_d   = last_i;
          state_d = FETCH;
        end
      end
      FETCH: begin
        if (abort_i) begin
          last_d  = 1'b0;
          state_d = IDLE;
        end else if (bus.gnt) begin
          data_d  = bus.rd;
          oidx_d  = idx_q;
          last_d  = (idx_q == end_q);
          state_d = SEND;
        end
      end
      SEND: begin
        // abort beats a handshake arriving in the same cycle.
        if (abort_i) begin
          last_d  = 1'b0;
          state_d = IDLE;
        end else if (bus.out_ready) begin
          if (last_q) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            idx_d   = idx_next;
            state_d = FETCH;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      end_q   <= '0;
      oidx_q  <= '0;
      data_q  <= '0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      end_q   <= end_d;
      oidx_q  <= oidx_d;
      data_q  <= data_d;
      last_q  <= last_d;
      done_q  <= done_d;
    end
  end

  // ra follows the working index, so it holds its last value in IDLE/SEND.
  assign bus.ra        = idx_q;
  assign bus.req       = (state_q == FETCH);
  assign bus.out_valid = (state_q == SEND);
  assign bus.out_data  = data_q;
  assign bus.out_idx   = oidx_q;
  assign bus.out_last  = last_q;
  assign busy_o        = (state_q != IDLE);
  assign done_o        = done_q;
  assign state_o       = state_q;

endmodule
